// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, sync/active decode and line/frame strobes on a pixel enable.
// Define VGA_TIMING_FRAME_COUNT_EN to build the 8-bit frame counter; otherwise frame_count reads 0.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CNT_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_count
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC - 1;
  localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC - 1;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SB_C  = CNT_W'(H_SYNC_BEG);
  localparam logic [CNT_W-1:0] H_SE_C  = CNT_W'(H_SYNC_END);
  localparam logic [CNT_W-1:0] V_SB_C  = CNT_W'(V_SYNC_BEG);
  localparam logic [CNT_W-1:0] V_SE_C  = CNT_W'(V_SYNC_END);

  // Counter width must cover both totals.
  if ((64'd1 << CNT_W) < 64'(H_TOTAL) || (64'd1 << CNT_W) < 64'(V_TOTAL)) begin : g_cnt_w_check
    $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
  end

  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             active_q, active_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  // Next raster position, then decode from that position so flags line up with col/row.
  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_ce) begin
      if (col_q == H_LAST) begin
        col_d = '0;
        row_d = (row_q == V_LAST) ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
      line_start_d  = (col_d == '0);
      frame_start_d = (col_d == '0) && (row_d == '0);
    end
    hsync_d  = ((col_d >= H_SB_C) && (col_d <= H_SE_C)) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d  = ((row_d >= V_SB_C) && (row_d <= V_SE_C)) ? V_SYNC_POL : ~V_SYNC_POL;
    active_d = (col_d < H_ACT_C) && (row_d < V_ACT_C);
  end

  // Reset parks the raster on the last pixel so the first step lands on (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q         <= H_LAST;
      row_q         <= V_LAST;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Counts in the same edge that raises frame_start, so frame 1 reads 1.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = 8'd0;
`endif

  assign col         = col_q;
  assign row         = row_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default VGA instance plus a tiny positive-polarity instance,
// both checked every cycle against a raster model driven by the count of pixel steps.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  = 1'b0;
  logic pix_ce = 1'b0;

  logic       hs1, vs1, act1, ls1, fs1;
  logic [9:0] col1, row1;
  logic [7:0] fc1;

  logic       hs2, vs2, act2, ls2, fs2;
  logic [3:0] col2, row2;
  logic [7:0] fc2;

  vga_timing_gen u_dut1 (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .hsync(hs1), .vsync(vs1), .active(act1), .col(col1), .row(row1),
    .line_start(ls1), .frame_start(fs1), .frame_count(fc1)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(4)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .hsync(hs2), .vsync(vs2), .active(act2), .col(col2), .row(row2),
    .line_start(ls2), .frame_start(fs2), .frame_count(fc2)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  longint k       = 0;   // pixel steps since the last reset
  bit     stepped = 1'b0;
  bit     cmp_en  = 1'b0;
  longint clk_cnt = 0;
  longint ls_prev = -1;
  longint ls_last = -1;

`ifdef VGA_TIMING_FRAME_COUNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Expected outputs from the step count: step n (n>=1) shows raster position n-1 of the frame.
  task automatic check_dut(input string tag,
                           input int ha, input int hf, input int hs, input int hb,
                           input int va, input int vf, input int vs, input int vb,
                           input bit hp, input bit vp,
                           input logic [31:0] a_col, input logic [31:0] a_row,
                           input logic a_hs, input logic a_vs, input logic a_act,
                           input logic a_ls, input logic a_fs, input logic [7:0] a_fc);
    int     ht, vt, c, r;
    longint ft, p, fc;
    bit     in_hs, in_vs;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    ft = longint'(ht) * vt;
    if (k == 0) begin
      c  = ht - 1;
      r  = vt - 1;
      fc = 0;
    end else begin
      p  = (k - 1) % ft;
      c  = int'(p % ht);
      r  = int'(p / ht);
      fc = FC_EN ? (((k - 1) / ft) + 1) % 256 : 0;
    end
    in_hs = (c >= ha + hf) && (c < ha + hf + hs);
    in_vs = (r >= va + vf) && (r < va + vf + vs);
    chk({tag, "_col"}, a_col, 32'(c));
    chk({tag, "_row"}, a_row, 32'(r));
    chk({tag, "_hsync"}, 32'(a_hs), 32'(in_hs ? hp : !hp));
    chk({tag, "_vsync"}, 32'(a_vs), 32'(in_vs ? vp : !vp));
    chk({tag, "_active"}, 32'(a_act), 32'((c < ha) && (r < va)));
    chk({tag, "_line_start"}, 32'(a_ls), 32'(stepped && c == 0));
    chk({tag, "_frame_start"}, 32'(a_fs), 32'(stepped && c == 0 && r == 0));
    chk({tag, "_frame_count"}, 32'(a_fc), 32'(fc));
  endtask

  always @(posedge clk) begin
    clk_cnt <= clk_cnt + 1;
    if (!rst_n) begin
      k       <= 0;
      stepped <= 1'b0;
    end else if (pix_ce) begin
      k       <= k + 1;
      stepped <= 1'b1;
    end else begin
      stepped <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check_dut("d1", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
                32'(col1), 32'(row1), hs1, vs1, act1, ls1, fs1, fc1);
      check_dut("d2", 8, 2, 3, 2, 5, 1, 2, 2, 1'b1, 1'b1,
                32'(col2), 32'(row2), hs2, vs2, act2, ls2, fs2, fc2);
      if (ls1 === 1'b1) begin
        ls_prev = ls_last;
        ls_last = clk_cnt;
      end
    end
  end

  task automatic tick(input bit ce);
    @(negedge clk);
    pix_ce = ce;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n  = 1'b0;
    pix_ce = 1'b1;
    repeat (n) tick(1'b1);
    @(negedge clk);
    rst_n  = 1'b1;
    pix_ce = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    pix_ce = 1'b0;
    repeat (3) tick(1'b0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    chk("lit_rst_col", 32'(col1), 32'd799);
    chk("lit_rst_row", 32'(row1), 32'd524);
    chk("lit_rst_hsync", 32'(hs1), 32'd1);
    chk("lit_rst_vsync", 32'(vs1), 32'd1);
    chk("lit_rst_active", 32'(act1), 32'd0);
    chk("lit_rst_strobes", 32'({ls1, fs1}), 32'd0);
    chk("lit_rst_hsync2", 32'(hs2), 32'd0);

    tick(1'b1);
    tick(1'b0);
    chk("lit_first_col", 32'(col1), 32'd0);
    chk("lit_first_row", 32'(row1), 32'd0);
    chk("lit_first_active", 32'(act1), 32'd1);
    chk("lit_first_fs", 32'(fs1), 32'd1);
    chk("lit_first_fc", 32'(fc2), FC_EN ? 32'd1 : 32'd0);
    tick(1'b0);
    chk("lit_fs_one_clk", 32'(fs1), 32'd0);

    repeat (10) tick(1'b1);
    tick(1'b0);
    chk("lit_d2_col10", 32'(col2), 32'd10);
    chk("lit_d2_hsync_hi", 32'(hs2), 32'd1);

    repeat (645) tick(1'b1);
    repeat (50) tick(1'b0);
    chk("lit_hold_col", 32'(col1), 32'd655);
    chk("lit_hold_hsync", 32'(hs1), 32'd1);
    tick(1'b1);
    tick(1'b0);
    chk("lit_col656", 32'(col1), 32'd656);
    chk("lit_hsync656", 32'(hs1), 32'd0);

    for (int i = 0; i < 9600; i++) tick(i % 4 == 0);
    chk("lit_line_period", 32'(ls_last - ls_prev), 32'd3200);

    for (int i = 0; i < 3000; i++) tick($urandom_range(0, 2) != 0);
    do_reset(2);
    for (int i = 0; i < 39000; i++) tick(1'b1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset(int'($urandom_range(1, 3)));
      else tick($urandom_range(0, 3) != 0);
    end
    tick(1'b0);
    tick(1'b0);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
